// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: APB slave that sequences an 8-bit UART receiver.
//   - Generates the 16x oversample tick (rx_en) from a programmable divisor.
//   - Drives the receiver / parity checker parity-enable (rx_parity_en).
//   - Captures each completed byte plus error flags into an RX FIFO.
//   - Exposes CTRL / BAUD / STATUS / DATA registers and a level interrupt.
//
// Optional feature: define RX_TIMEOUT_EN to build the idle-timeout counter
// (STATUS[6]). Without it, STATUS[6] reads 0 and never raises irq.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR[3:0]             byte address (bits [1:0] ignored)
//   PWDATA[31:0]           write data
//   PRDATA[31:0]           read data (combinational in the read access phase)
//   PREADY, PSLVERR        zero-wait-state ready, error response
//   rx_en                  one-cycle oversample tick to the receiver
//   rx_parity_en           parity enable (CTRL[1])
//   rx_done, rx_data, rx_busy, rx_err, rx_parity_err   receiver side
//   irq                    registered level interrupt
//
// APB handshake: a transfer is the setup phase (PSEL & ~PENABLE) followed by
// one access phase (PSEL & PENABLE). PREADY is always 1, so every access phase
// completes in one cycle; writes commit and pops happen at the clock edge that
// ends the access phase.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter logic [15:0] DEFAULT_DIV   = 16'd27,
    parameter int unsigned TIMEOUT_CHARS = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        rx_en,
    output logic        rx_parity_en,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_busy,
    input  logic        rx_err,
    input  logic        rx_parity_err,
    output logic        irq
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_BAUD = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_DATA = 2'd3;

    logic [2:0]    ctrl_q, ctrl_d;
    logic [15:0]   baud_q;
    logic [15:0]   baud_cnt_q;
    logic          rx_en_q;
    logic          done_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d, frm_q, frm_d, par_q, par_d;
    logic          irq_q;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          tmo_flag;
    logic          tmo_set;

    logic       wr_acc, rd_acc;
    logic [1:0] reg_sel;
    logic       empty, full;
    logic       push_ev, push_ok, pop, ovr_set;
    logic [4:0] w1c;            // clear mask for STATUS[6:2]
    logic [31:0] status_w;
    logic        unused_bits;

    assign wr_acc  = PSEL & PENABLE & PWRITE;
    assign rd_acc  = PSEL & PENABLE & ~PWRITE;
    assign reg_sel = PADDR[3:2];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

    assign push_ev = ctrl_q[0] & rx_done & ~done_q;
    assign pop     = rd_acc & (reg_sel == A_DATA) & ~empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign push_ok = push_ev & (~full | pop);
    assign ovr_set = push_ev & full & ~pop;

    assign w1c = (wr_acc && reg_sel == A_STAT) ? PWDATA[6:2] : 5'b0;

    // CTRL next value; the baud generator uses it so that clearing enable
    // suppresses a tick at the very edge the write commits.
    assign ctrl_d = (wr_acc && reg_sel == A_CTRL) ? PWDATA[2:0] : ctrl_q;

    always_comb begin
        count_d = count_q + CW'(push_ok) - CW'(pop);
        // Set wins over a simultaneous W1C clear.
        ovr_d = ovr_set | (ovr_q & ~w1c[0]);
        frm_d = (push_ev & rx_err) | (frm_q & ~w1c[1]);
        par_d = (push_ev & rx_parity_err) | (par_q & ~w1c[2]);
    end

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TMO_TICKS = TIMEOUT_CHARS * 160;
    localparam int unsigned TW = $clog2(TMO_TICKS + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          tmo_q;

    always_comb begin
        idle_d  = idle_q;
        tmo_set = 1'b0;
        if (!ctrl_q[0] || push_ev || pop) begin
            idle_d = '0;
        end else if (rx_en_q && !empty && !rx_busy && idle_q != TW'(TMO_TICKS)) begin
            idle_d  = idle_q + 1'b1;
            // Only the step onto the limit sets the flag, so a W1C clear
            // sticks while the counter sits at its hold value.
            tmo_set = (idle_d == TW'(TMO_TICKS));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_set | (tmo_q & ~w1c[4]);
        end
    end

    assign tmo_flag = tmo_q;
`else
    assign tmo_set  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    always_comb begin
        status_w       = '0;
        status_w[0]    = empty;
        status_w[1]    = full;
        status_w[2]    = ovr_q;
        status_w[3]    = frm_q;
        status_w[4]    = par_q;
        status_w[5]    = rx_busy;
        status_w[6]    = tmo_flag;
        status_w[11:8] = 4'(count_q);
    end

    always_comb begin
        PRDATA = '0;
        if (rd_acc) begin
            case (reg_sel)
                A_CTRL:  PRDATA = {29'b0, ctrl_q};
                A_BAUD:  PRDATA = {16'b0, baud_q};
                A_STAT:  PRDATA = status_w;
                default: PRDATA = empty ? 32'b0 : {22'b0, mem_q[rd_ptr_q]};
            endcase
        end
    end

    assign PREADY       = 1'b1;
    assign PSLVERR      = PSEL & PENABLE & (reg_sel == A_DATA) & (PWRITE | empty);
    assign rx_en        = rx_en_q;
    assign rx_parity_en = ctrl_q[1];
    assign irq          = irq_q;
    assign unused_bits  = ^{PADDR[1:0], PWDATA[31:16], tmo_set};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q     <= '0;
            baud_q     <= DEFAULT_DIV;
            baud_cnt_q <= '0;
            rx_en_q    <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            par_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            if (wr_acc && reg_sel == A_BAUD) baud_q <= PWDATA[15:0];

            // Down-counter: a tick every BAUD+1 cycles, reload on BAUD write.
            if (!ctrl_d[0]) begin
                baud_cnt_q <= '0;
                rx_en_q    <= 1'b0;
            end else if (wr_acc && reg_sel == A_BAUD) begin
                baud_cnt_q <= PWDATA[15:0];
                rx_en_q    <= 1'b0;
            end else if (baud_cnt_q == '0) begin
                baud_cnt_q <= baud_q;
                rx_en_q    <= 1'b1;
            end else begin
                baud_cnt_q <= baud_cnt_q - 1'b1;
                rx_en_q    <= 1'b0;
            end

            done_q <= ctrl_q[0] ? rx_done : 1'b0;

            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            frm_q   <= frm_d;
            par_q   <= par_d;
            irq_q   <= ctrl_q[2] & (~empty | ovr_q | tmo_flag);
        end
    end

    always_ff @(posedge PCLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= {rx_err, rx_parity_err, rx_data};
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        rx_en, rx_parity_en;
  logic        rx_done, rx_busy, rx_err, rx_parity_err;
  logic [7:0]  rx_data;
  logic        irq;

  int errors = 0;
  int checks = 0;

`ifdef RX_TIMEOUT_EN
  localparam bit TMO_BUILD = 1'b1;
`else
  localparam bit TMO_BUILD = 1'b0;
`endif

  uart_rx_ctrl dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .rx_en(rx_en),
    .rx_parity_en(rx_parity_en), .rx_done(rx_done), .rx_data(rx_data),
    .rx_busy(rx_busy), .rx_err(rx_err), .rx_parity_err(rx_parity_err),
    .irq(irq)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic perr, input logic ferr, input int hold);
    rx_data = d; rx_parity_err = perr; rx_err = ferr; rx_done = 1'b1;
    repeat (hold) begin
      @(posedge PCLK); #1;
    end
    rx_done = 1'b0; rx_parity_err = 1'b0; rx_err = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    PRESETn = 1'b0;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    rx_done = 0; rx_data = 0; rx_busy = 0; rx_err = 0; rx_parity_err = 0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({rx_en, rx_parity_en, irq, PSLVERR} !== 4'b0 || PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rx_en=%0b par=%0b irq=%0b slverr=%0b prdata=%h, want all 0",
               rx_en, rx_parity_en, irq, PSLVERR, PRDATA);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    apb_read(4'h0, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got %h err=%0b, want 0 err=0", d, e);
    end
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'd27) begin
      errors++; $display("FAIL reset_baud: got %h, want 0000001b", d);
    end
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL reset_status: got %h, want 00000001", d);
    end
  endtask

  task automatic test_baud();
    logic e;
    logic [31:0] d;
    int last, npulse, gaps_bad, highs;
    apb_write(4'h4, 32'd3, e);
    apb_write(4'h0, 32'h1, e);
    last = -1; npulse = 0; gaps_bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge PCLK);
      if (rx_en) begin
        if (last >= 0 && (i - last) != 4) gaps_bad++;
        last = i;
        npulse++;
      end
    end
    @(posedge PCLK); #1;
    checks++;
    if (npulse != 6 || gaps_bad != 0) begin
      errors++; $display("FAIL baud_period4: got %0d pulses, %0d bad gaps, want 6 pulses, 0 bad gaps", npulse, gaps_bad);
    end
    apb_write(4'h0, 32'h0, e);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge PCLK);
      if (rx_en) highs++;
    end
    @(posedge PCLK); #1;
    checks++;
    if (highs != 0) begin
      errors++; $display("FAIL baud_disabled: got %0d ticks, want 0", highs);
    end
    apb_write(4'h4, 32'd0, e);
    apb_write(4'h0, 32'h1, e);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (rx_en) highs++;
    end
    @(posedge PCLK); #1;
    checks++;
    if (highs != 8) begin
      errors++; $display("FAIL baud_zero_every_cycle: got %0d of 8 ticks, want 8", highs);
    end
    apb_read(4'h4, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL baud_readback: got %h, want 0", d);
    end
  endtask

  task automatic test_single();
    logic e;
    logic [31:0] d;
    apb_write(4'h0, 32'h1, e);
    send_byte(8'hA5, 1'b0, 1'b0, 5);
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL single_status_one: got %h, want 00000100", d);
    end
    apb_read(4'hC, d, e);
    checks++;
    if (d !== 32'h0A5 || e !== 1'b0) begin
      errors++; $display("FAIL single_data: got %h err=%0b, want 000000a5 err=0", d, e);
    end
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL single_status_empty: got %h, want 00000001", d);
    end
    // contents survive a disable, and capture is off while disabled
    send_byte(8'h42, 1'b0, 1'b0, 1);
    apb_write(4'h0, 32'h0, e);
    send_byte(8'h77, 1'b0, 1'b0, 2);
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL disable_preserve: got %h, want 00000100", d);
    end
    apb_write(4'h0, 32'h1, e);
    apb_read(4'hC, d, e);
    checks++;
    if (d !== 32'h042) begin
      errors++; $display("FAIL disable_data: got %h, want 00000042", d);
    end
    apb_write(4'hC, 32'h55, e);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL data_write_slverr: got %0b, want 1", e);
    end
  endtask

  task automatic test_overflow();
    logic e;
    logic [31:0] d;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0, 1'b0, 1);
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h806) begin
      errors++; $display("FAIL overflow_status: got %h, want 00000806", d);
    end
    for (int i = 1; i <= 8; i++) begin
      apb_read(4'hC, d, e);
      checks++;
      if (d !== 32'(i) || e !== 1'b0) begin
        errors++; $display("FAIL overflow_pop%0d: got %h err=%0b, want %h err=0", i, d, e, 32'(i));
      end
    end
    apb_read(4'hC, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL empty_read: got %h err=%0b, want 0 err=1", d, e);
    end
    apb_write(4'h8, 32'h4, e);
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL overrun_w1c: got %h, want 00000001", d);
    end
  endtask

  task automatic test_parity_irq();
    logic e;
    logic [31:0] d;
    apb_write(4'h0, 32'h7, e);
    @(negedge PCLK);
    checks++;
    if (rx_parity_en !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL parity_en_irq_idle: got par=%0b irq=%0b, want 1 0", rx_parity_en, irq);
    end
    @(posedge PCLK); #1;
    rx_data = 8'h3C; rx_parity_err = 1'b1; rx_done = 1'b1;
    @(posedge PCLK); #1;                       // push edge
    rx_done = 1'b0; rx_parity_err = 1'b0;
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_latency_early: got %0b, want 0", irq);
    end
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %0b, want 1", irq);
    end
    @(posedge PCLK); #1;
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h110) begin
      errors++; $display("FAIL parity_status: got %h, want 00000110", d);
    end
    apb_write(4'h8, 32'h10, e);
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL parity_w1c: got %h, want 00000100", d);
    end
    apb_read(4'hC, d, e);
    checks++;
    if (d !== 32'h13C) begin
      errors++; $display("FAIL parity_data: got %h, want 0000013c", d);
    end
    @(negedge PCLK);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_fall: got %0b, want 0", irq);
    end
    @(posedge PCLK); #1;
    apb_write(4'h0, 32'h1, e);
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0, 1);
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h802) begin
      errors++; $display("FAIL full_status: got %h, want 00000802", d);
    end
    // pop and push meet at the same edge while full
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'hC;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; rx_data = 8'h18; rx_done = 1'b1;
    @(negedge PCLK);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_done = 1'b0;
    checks++;
    if (d !== 32'h10) begin
      errors++; $display("FAIL simul_pop_data: got %h, want 00000010", d);
    end
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h802) begin
      errors++; $display("FAIL simul_status: got %h, want 00000802", d);
    end
    for (int i = 1; i <= 8; i++) begin
      apb_read(4'hC, d, e);
      checks++;
      if (d !== 32'h10 + 32'(i)) begin
        errors++; $display("FAIL drain%0d: got %h, want %h", i, d, 32'h10 + 32'(i));
      end
    end
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL drain_empty: got %h, want 00000001", d);
    end
  endtask

  task automatic test_timeout();
    logic e;
    logic [31:0] d;
    apb_write(4'h4, 32'd0, e);
    apb_write(4'h0, 32'h5, e);
    send_byte(8'h55, 1'b0, 1'b0, 1);
    repeat (600) @(posedge PCLK);
    #1;
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL timeout_early: got %h, want 00000100", d);
    end
    repeat (80) @(posedge PCLK);
    #1;
    apb_read(4'h8, d, e);
    checks++;
    if (d !== (TMO_BUILD ? 32'h140 : 32'h100)) begin
      errors++; $display("FAIL timeout_flag: got %h, want %h", d, TMO_BUILD ? 32'h140 : 32'h100);
    end
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL timeout_irq: got %0b, want 1", irq);
    end
    @(posedge PCLK); #1;
    apb_read(4'hC, d, e);
    checks++;
    if (d !== 32'h055) begin
      errors++; $display("FAIL timeout_data: got %h, want 00000055", d);
    end
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if (irq !== TMO_BUILD) begin
      errors++; $display("FAIL timeout_irq_after_pop: got %0b, want %0b", irq, TMO_BUILD);
    end
    @(posedge PCLK); #1;
    apb_write(4'h8, 32'h40, e);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL timeout_irq_cleared: got %0b, want 0", irq);
    end
    @(posedge PCLK); #1;
    apb_read(4'h8, d, e);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL timeout_w1c: got %h, want 00000001", d);
    end
  endtask

  initial begin
    test_reset();
    test_baud();
    test_single();
    test_overflow();
    test_parity_irq();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
